// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Purpose  : Shared constants and the 4-bit lookahead carry function.
// Revision : 1.0
// ============================================================================
package cla_pkg;

    localparam int GRP_W = 4;

    // In-group carries c[3:0] plus group propagate/generate for the carry-out.
    typedef struct packed {
        logic [3:0] c;
        logic       pg;
        logic       gg;
    } cla4_t;

    function automatic cla4_t cla4_carries(input logic [3:0] p,
                                           input logic [3:0] g,
                                           input logic       c0);
        cla4_t r;
        r.c[0] = c0;
        r.c[1] = g[0] | (p[0] & c0);
        r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c0);
        r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
        r.pg   = &p;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group4.sv
`default_nettype none
// ============================================================================
// Module   : cla_group4
// Purpose  : Combinational 4-bit carry-lookahead group (sum, carry-out, c3).
// Revision : 1.0
// ============================================================================
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    cla4_t      w_cla;

    assign w_p   = a ^ b;
    assign w_g   = a & b;
    assign w_cla = cla4_carries(w_p, w_g, ci);

    assign s  = w_p ^ w_cla.c;
    assign co = w_cla.gg | (w_cla.pg & ci);
    assign c3 = w_cla.c[3];

endmodule
`default_nettype wire

// File: rtl/cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_addsub_pipe
// Purpose  : Pipelined carry-lookahead add/subtract with valid/ready handshake.
// Revision : 1.0
// ============================================================================
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSTAGE = WIDTH / (GRP_W * GPS);

    if ((GPS < 1) || (WIDTH < GRP_W * GPS) || ((WIDTH % (GRP_W * GPS)) != 0))
    begin : g_param_check
        $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of 4*GPS");
    end

    logic             w_en;

    // Rank k holds the operands waiting for stage k plus the sum bits below it.
    logic [NSTAGE-1:0] r_vld;
    logic [NSTAGE-1:0] r_c;
    logic [WIDTH-1:0]  r_a [NSTAGE];
    logic [WIDTH-1:0]  r_b [NSTAGE];
    logic [WIDTH-1:0]  r_s [NSTAGE];

    logic [WIDTH-1:0]  w_sn [NSTAGE];
    logic [NSTAGE-1:0] w_co;
    logic              w_msb_c;

    logic              r_ovld;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    assign w_en = ~r_ovld | out_ready;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [GPS:0]         w_gc;
        logic [GPS-1:0]       w_g3;
        logic [GPS-1:0][3:0]  w_gs;
        logic [WIDTH-1:0]     w_s;

        assign w_gc[0] = r_c[k];

        for (genvar g = 0; g < GPS; g++) begin : g_grp
            localparam int C_LSB = (k * GPS + g) * GRP_W;
            cla_group4 u_grp (
                .a  (r_a[k][C_LSB +: GRP_W]),
                .b  (r_b[k][C_LSB +: GRP_W]),
                .ci (w_gc[g]),
                .s  (w_gs[g]),
                .co (w_gc[g+1]),
                .c3 (w_g3[g])
            );
        end

        always_comb begin
            w_s = r_s[k];
            for (int g = 0; g < GPS; g++) begin
                w_s[(k * GPS + g) * GRP_W +: GRP_W] = w_gs[g];
            end
        end

        assign w_sn[k] = w_s;
        assign w_co[k] = w_gc[GPS];

        if (k == NSTAGE - 1) begin : g_last
            assign w_msb_c = w_g3[GPS-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_c    <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
            r_ovld <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            // Subtract is A + ~B + 1; cin only matters for add.
            r_vld[0] <= in_valid;
            r_a[0]   <= a;
            r_b[0]   <= sub ? ~b : b;
            r_c[0]   <= sub | cin;
            r_s[0]   <= '0;
            for (int k = 1; k < NSTAGE; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_a[k]   <= r_a[k-1];
                r_b[k]   <= r_b[k-1];
                r_c[k]   <= w_co[k-1];
                r_s[k]   <= w_sn[k-1];
            end
            r_ovld <= r_vld[NSTAGE-1];
            r_sum  <= w_sn[NSTAGE-1];
            r_cout <= w_co[NSTAGE-1];
            r_ovf  <= w_co[NSTAGE-1] ^ w_msb_c;
            r_zero <= ~|w_sn[NSTAGE-1];
        end
    end

    assign in_ready  = w_en;
    assign out_valid = r_ovld;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the calculator datapath.
- Generalises the 4-bit lookahead carry unit to WIDTH bits, built from 4-bit lookahead groups.
- Carries ripple between groups only through pipeline registers, so per-stage logic stays one or a few groups deep.
- Adds subtract mode, signed-overflow and zero flags, and a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 × GPS; otherwise elaboration fails.
- GPS, 1, number of 4-bit groups resolved per pipeline stage.
- NSTAGE (localparam), WIDTH/(4*GPS), pipeline depth; equals latency in cycles.

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand set presented
- in_ready  out  1  block accepts operand set this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  1 = A − B, 0 = A + B
- cin  in  1  carry-in for add; ignored when sub=1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset: the synchronous reset is sampled on the rising clk edge while rst_n=0.
  - All stage valid bits, sum, cout, ovf and zero are forced to 0.
  - in_ready reads 1 during and after reset.
  - Reset mid-operation discards all in-flight results; none appears after release.
- Operand conditioning at accept: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Per group i: p = a ^ b_eff, g = a & b_eff.
  - In-group carries: c1 = g0 | p0·c0, …, through c4 (full 4-level lookahead).
  - Group sum = p ^ {c3,c2,c1,c0}.
- Stage k (0..NSTAGE−1) resolves groups k·GPS to k·GPS+GPS−1.
  - It uses the carry registered by stage k−1 (stage 0 uses c0).
  - Within a stage, groups chain combinationally via group carry-out.
- Each stage register holds:
  - the low sum bits already resolved;
  - the unresolved a/b_eff bits;
  - the carry into the next group;
  - the carry into the MSB position, needed for ovf.
- Final stage:
  - cout = carry out of bit WIDTH−1.
  - ovf = cout ^ carry into bit WIDTH−1.
  - zero = ~|sum.
- Latency: an operand set accepted at edge N appears with out_valid=1 after edge N+NSTAGE, provided there is no stall.
- Handshake:
  - Global advance enable en = ~out_valid | out_ready.
  - in_ready = en, combinational.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - When en=0, every stage holds, including bubbles, and outputs stay stable.
  - in_valid=0 while en=1 inserts a bubble (valid bit 0).
  - Bubbles are not collapsed.
- Throughput: one result per cycle when out_ready is held 1.
- Ordering: strictly FIFO. No drop, no duplicate.
- Simultaneous events:
  - Output transfer and input accept in the same cycle are both legal.
  - rst_n=0 overrides any handshake in that cycle.
- Stability: sum, cout, ovf and zero are registered and change only on advance edges or reset.
- Wrap-around: modulo 2^WIDTH. 0xFFFF+1 gives 0x0000 with cout=1.

Decomposition:
- Shared package cla_pkg holds:
  - localparam GRP_W = 4;
  - a function computing 4-bit group carries and group P/G from p, g and c0.
- One combinational sub-module, cla_group4: inputs a[3:0], b[3:0], ci; outputs s[3:0], co, c3 (carry into bit 3).
  - It is instantiated GPS times per stage via generate.
  - c3 feeds ovf in the top group.
- All pipeline registers, the handshake and flag logic live in cla_addsub_pipe.

Test Plan (WIDTH=16, GPS=1, NSTAGE=4):
1. rst_n low 3 cycles with in_valid=1, a=0x1234 → out_valid=0, sum=0x0000, in_ready=1; no output appears after release.
2. Add a=0xFFFF, b=0x0001, cin=0, out_ready=1 → 4 edges later: sum=0x0000, cout=1, zero=1, ovf=0.
3. Sub a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1, zero=0; and sub a=0x0003, b=0x0005 → sum=0xFFFE, cout=0, ovf=0.
4. Add a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, ovf=1, cout=0; same with cin=1 and sub=1 on b=0x0000 → sum=0x7FFF, ovf=0 (cin ignored).
5. Stream 6 back-to-back adds (k+0x0100 for k=0..5), out_ready=0 for 3 cycles once the first result is valid → in_ready=0 and outputs frozen during the stall; all 6 results emerge in order, none lost or duplicated.
6. Reset asserted 2 cycles after accepting 2 operations, then released → out_valid stays 0 until new input; a fresh add 0x0010+0x0020 yields 0x0030 after exactly 4 cycles.
